// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues in-order word reads to
// instruction memory, buffers responses in a small FIFO and hands {pc, instr} to
// decode over valid/ready. A redirect flushes buffered and in-flight fetches.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [6:0]  dec_opcode,
  output logic        fetch_misalign
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {
    FETCH,
    HALT
  } state_t;

  state_t        state;
  logic          misalign_q;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;

  // Decode buffer
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Addresses of live (not-to-be-dropped) outstanding requests, oldest at tag_rd
  logic [31:0]   tag_pc [FIFO_DEPTH];
  logic [PW-1:0] tag_rd;
  logic [PW-1:0] tag_wr;

  logic [CW:0]   in_use;
  logic          req_fire;
  logic          rsp_drop;
  logic          rsp_live;
  logic          push;
  logic          pop;

  // Credit, handshake qualifiers and decode-side outputs
  always_comb begin
    in_use         = {1'b0, outstanding} + {1'b0, count};
    imem_req_valid = rst_n && (state == FETCH) && !redirect_valid
                     && (in_use < (CW+1)'(FIFO_DEPTH));
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_drop       = imem_rsp_valid && (drop_cnt != '0);
    rsp_live       = imem_rsp_valid && (drop_cnt == '0);
    push           = rsp_live && !redirect_valid;
    dec_valid      = (count != '0);
    pop            = dec_valid && dec_ready && !redirect_valid;
    dec_pc         = fifo_pc[rd_ptr];
    dec_instr      = fifo_instr[rd_ptr];
    dec_opcode     = fifo_instr[rd_ptr][6:0];
    fetch_misalign = misalign_q;
  end

  // Fetch/halt FSM; any redirect decides the next state from its alignment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      misalign_q <= 1'b0;
    end else if (redirect_valid) begin
      if (redirect_pc[1:0] != 2'b00) begin
        state      <= HALT;
        misalign_q <= 1'b1;
      end else begin
        state      <= FETCH;
        misalign_q <= 1'b0;
      end
    end
  end

  // Fetch PC, outstanding/drop accounting and request tag queue.
  // On redirect every live outstanding request becomes a drop, so the tag
  // queue only ever holds requests whose responses will be buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
      tag_pc      <= '{default: '0};
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_pc;
      drop_cnt    <= drop_cnt + outstanding - CW'(imem_rsp_valid);
      outstanding <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
    end else begin
      if (req_fire) begin
        tag_pc[tag_wr] <= fetch_pc;
        tag_wr         <= tag_wr + PW'(1);
        fetch_pc       <= fetch_pc + 32'd4;
      end
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (rsp_live) begin
        tag_rd <= tag_rd + PW'(1);
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_live);
    end
  end

  // Decode FIFO: push live responses tagged with their PC, pop on decode handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_pc    <= '{default: '0};
      fifo_instr <= '{default: '0};
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr]    <= tag_pc[tag_rd];
        fifo_instr[wr_ptr] <= imem_rsp_data;
        wr_ptr             <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // The credit rule keeps the buffer from ever being pushed while full
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: randomized memory/decode/redirect traffic
// checked every cycle against a queue-based reference model, plus directed
// scenarios with hand-computed expectations.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [6:0]  dec_opcode;
  logic        fetch_misalign;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_opcode(dec_opcode),
    .fetch_misalign(fetch_misalign)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: expected fetch PC, halt flag, PCs of live requests,
  // PCs sitting in the decode buffer, and count of responses still to discard
  logic [31:0] m_pc;
  bit          m_halt;
  logic [31:0] m_live[$];
  logic [31:0] m_fifo[$];
  int          m_drop;

  // Memory model: in-order responses with a due cycle
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mem_q[$];
  int unsigned lat_lo = 0;
  int unsigned lat_hi = 0;

  // Observations taken from the DUT for the directed literal checks
  logic [31:0] pop_log[$];
  logic [31:0] req_log[$];
  int          first_dv_cyc = -1;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_q(input string name, input logic [31:0] q[$], input int idx,
                       input logic [31:0] exp);
    if (idx < q.size()) begin
      chk(name, q[idx], exp);
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: only %0d entries seen, expected entry %0d = %08h", name, q.size(), idx, exp);
    end
  endtask

  // One clock cycle: drive memory response, compare outputs, advance model
  task automatic step();
    bit          rsp;
    bit          exp_rv;
    bit          pop;
    bit          fire;
    logic [31:0] hi;
    int unsigned d;
    rsp = 1'b0;
    if (mem_q.size() != 0) begin
      if (mem_q[0].due <= cyc) rsp = 1'b1;
    end
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? memf(mem_q[0].addr) : 32'h0;
    #1;
    exp_rv = !m_halt && !redirect_valid && ((m_live.size() + m_fifo.size()) < DEPTH);
    chk("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_rv});
    chk("req_addr", imem_req_addr, m_pc);
    chk("dec_valid", {31'd0, dec_valid}, {31'd0, m_fifo.size() != 0});
    chk("misalign", {31'd0, fetch_misalign}, {31'd0, m_halt});
    if (m_fifo.size() != 0) begin
      hi = memf(m_fifo[0]);
      chk("dec_pc", dec_pc, m_fifo[0]);
      chk("dec_instr", dec_instr, hi);
      chk("dec_opcode", {25'd0, dec_opcode}, {25'd0, hi[6:0]});
    end
    if (dec_valid && dec_ready && !redirect_valid) pop_log.push_back(dec_pc);
    if (imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);
    if (dec_valid && first_dv_cyc < 0) first_dv_cyc = cyc;

    fire = exp_rv && imem_req_ready;
    pop  = (m_fifo.size() != 0) && dec_ready;
    if (rsp) void'(mem_q.pop_front());
    if (redirect_valid) begin
      m_drop = m_drop + m_live.size() - (rsp ? 1 : 0);
      m_live.delete();
      m_fifo.delete();
      m_pc   = redirect_pc;
      m_halt = (redirect_pc[1:0] != 2'b00);
    end else begin
      if (pop) void'(m_fifo.pop_front());
      if (rsp) begin
        if (m_drop > 0) m_drop--;
        else if (m_live.size() != 0) m_fifo.push_back(m_live.pop_front());
      end
      if (fire) begin
        d = $urandom_range(lat_hi, lat_lo);
        mem_q.push_back('{addr: m_pc, due: cyc + 1 + int'(d)});
        m_live.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  // Assert reset (at a negedge), check outputs immediately, clear model, release
  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_ready      = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    #1;
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
    chk("rst_misalign", {31'd0, fetch_misalign}, 32'd0);
    chk("rst_dec_pc", dec_pc, 32'd0);
    chk("rst_dec_instr", dec_instr, 32'd0);
    chk("rst_dec_opcode", {25'd0, dec_opcode}, 32'd0);
    m_pc   = RESET_PC;
    m_halt = 1'b0;
    m_drop = 0;
    m_live.delete();
    m_fifo.delete();
    mem_q.delete();
    pop_log.delete();
    req_log.delete();
    first_dv_cyc = -1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int          n;
    logic [31:0] r;
    @(negedge clk);

    // Streaming from reset with minimum latency
    do_reset();
    lat_lo = 0; lat_hi = 0;
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    repeat (12) step();
    chk("t1_first_dec_cycle", first_dv_cyc, 32'd2);
    for (int i = 0; i < 4; i++) chk_q("t1_pop_pc", pop_log, i, 32'(4 * i));

    // Decoder stalled: buffer fills, requests stop, then drain in order
    do_reset();
    imem_req_ready = 1'b1;
    dec_ready      = 1'b0;
    repeat (10) step();
    chk("t2_req_count", req_log.size(), 32'd2);
    chk("t2_req_valid_full", {31'd0, imem_req_valid}, 32'd0);
    chk("t2_dec_valid_full", {31'd0, dec_valid}, 32'd1);
    dec_ready = 1'b1;
    repeat (8) step();
    chk_q("t2_pop0", pop_log, 0, 32'h0);
    chk_q("t2_pop1", pop_log, 1, 32'h4);
    chk_q("t2_pop2", pop_log, 2, 32'h8);

    // Redirect with two requests in flight
    do_reset();
    lat_lo = 3; lat_hi = 3;
    imem_req_ready = 1'b1;
    dec_ready      = 1'b0;
    repeat (2) step();
    redirect_to(32'h0000_0100);
    lat_lo = 0; lat_hi = 0;
    dec_ready = 1'b1;
    repeat (10) step();
    chk_q("t3_req_after_redirect", req_log, 2, 32'h0000_0100);
    chk_q("t3_first_pop", pop_log, 0, 32'h0000_0100);
    chk_q("t3_second_pop", pop_log, 1, 32'h0000_0104);

    // Redirect coinciding with a response and a decode pop
    do_reset();
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    repeat (2) step();
    redirect_to(32'h0000_0300);
    chk("t4_dec_valid_cleared", {31'd0, dec_valid}, 32'd0);
    chk("t4_no_pop_in_redirect", pop_log.size(), 32'd0);
    repeat (8) step();
    chk_q("t4_first_pop", pop_log, 0, 32'h0000_0300);

    // Misaligned redirect halts fetch; aligned redirect resumes
    redirect_to(32'h0000_0102);
    n = req_log.size();
    repeat (6) step();
    chk("t5_misalign_set", {31'd0, fetch_misalign}, 32'd1);
    chk("t5_no_requests", req_log.size() - n, 32'd0);
    chk("t5_req_valid_low", {31'd0, imem_req_valid}, 32'd0);
    redirect_to(32'h0000_0200);
    chk("t5_misalign_clear", {31'd0, fetch_misalign}, 32'd0);
    n = req_log.size();
    repeat (6) step();
    chk_q("t5_resume_addr", req_log, n, 32'h0000_0200);

    // PC wraps past the top of the address space, then reset mid-stream
    redirect_to(32'hFFFF_FFFC);
    n = req_log.size();
    repeat (6) step();
    chk_q("t6_top_addr", req_log, n, 32'hFFFF_FFFC);
    chk_q("t6_wrap_addr", req_log, n + 1, 32'h0000_0000);
    do_reset();
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    repeat (6) step();
    chk_q("t6_restart_addr", req_log, 0, RESET_PC);
    chk_q("t6_restart_pop", pop_log, 0, RESET_PC);

    // Randomized traffic against the model
    lat_lo = 0; lat_hi = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
        lat_lo = 0; lat_hi = 1;
      end
      imem_req_ready = ($urandom_range(99) < 70);
      dec_ready      = ($urandom_range(99) < 60);
      redirect_valid = ($urandom_range(99) < 4);
      if (redirect_valid) begin
        r = $urandom();
        if ($urandom_range(7) == 0) r = 32'hFFFF_FFF4;
        r[1:0] = ($urandom_range(4) == 0) ? 2'b10 : 2'b00;
        redirect_pc = r;
      end
      step();
    end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
